// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit:
// opcode encoding, signed-overflow rule and width-parametrised saturation limits.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Widest operand the saturation helpers can describe.
  localparam int MAX_W = 64;

  // Signed overflow from the sign bits of A, B and the result.
  function automatic logic ovf_calc(input logic is_sub, input logic a_s,
                                    input logic b_s, input logic r_s);
    return is_sub ? ((a_s != b_s) && (r_s != a_s))
                  : ((a_s == b_s) && (r_s != a_s));
  endfunction

  // Most positive two's-complement value of width w (0111..1).
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Most negative two's-complement value of width w (1000..0).
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// Stallable register slice carrying {valid, y, zero, ovf}; one cycle of latency.
// Payload only loads with valid data, so drained outputs keep their last value.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          vld_d,
  input  logic [YW-1:0] y_d,
  input  logic          zero_d,
  input  logic          ovf_d,
  output logic          vld_q,
  output logic [YW-1:0] y_q,
  output logic          zero_q,
  output logic          ovf_q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      y_q    <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
      if (vld_d) begin
        y_q    <= y_d;
        zero_q <= zero_d;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined ADD/SUB/ADC/SBB unit, PIPE_STAGES cycles latency, one result per cycle.
// Whole pipe freezes while the output is held; ADDSUB_SAT_EN clamps overflowed results.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  op_e                   op,
  input  logic                  cin,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   y_out,
  output logic                  zero,
  output logic                  ovf
);

  localparam int W = DATA_WIDTH;

`ifdef ADDSUB_SAT_EN
  localparam logic [MAX_W-1:0] SAT_MAX_L = sat_max(W);
  localparam logic [MAX_W-1:0] SAT_MIN_L = sat_min(W);
  localparam logic [W-1:0]     SAT_MAX   = SAT_MAX_L[W-1:0];
  localparam logic [W-1:0]     SAT_MIN   = SAT_MIN_L[W-1:0];
`endif

  logic         stall;
  logic         adv;
  logic         sub_op;
  logic         c_in;
  logic [W:0]   a_x;
  logic [W:0]   b_x;
  logic [W:0]   sum;
  logic [W:0]   res_d;
  logic         zero_d;
  logic         ovf_d;

  logic [PIPE_STAGES:0] vld_s;
  logic [PIPE_STAGES:0] zero_s;
  logic [PIPE_STAGES:0] ovf_s;
  logic [W:0]           y_s [PIPE_STAGES+1];

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = rst && !stall;

  // Zero-extended operands make bit W the carry (add) or borrow (sub).
  always_comb begin
    sub_op = (op == OP_SUB) || (op == OP_SBB);
    c_in   = ((op == OP_ADC) || (op == OP_SBB)) ? cin : 1'b0;
    a_x    = {1'b0, data1};
    b_x    = {1'b0, data2};
    sum    = sub_op ? (a_x - b_x - {{W{1'b0}}, c_in})
                    : (a_x + b_x + {{W{1'b0}}, c_in});
    ovf_d  = ovf_calc(sub_op, data1[W-1], data2[W-1], sum[W-1]);
    res_d  = sum;
`ifdef ADDSUB_SAT_EN
    if (ovf_d) begin
      res_d[W-1:0] = data1[W-1] ? SAT_MIN : SAT_MAX;
    end
`endif
    zero_d = (res_d[W-1:0] == '0);
  end

  assign vld_s[0]  = in_valid && in_ready;
  assign y_s[0]    = res_d;
  assign zero_s[0] = zero_d;
  assign ovf_s[0]  = ovf_d;

  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    addsub_stage #(.YW(W + 1)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .vld_d  (vld_s[g]),
      .y_d    (y_s[g]),
      .zero_d (zero_s[g]),
      .ovf_d  (ovf_s[g]),
      .vld_q  (vld_s[g+1]),
      .y_q    (y_s[g+1]),
      .zero_q (zero_s[g+1]),
      .ovf_q  (ovf_s[g+1])
    );
  end

  assign out_valid = vld_s[PIPE_STAGES];
  assign y_out     = y_s[PIPE_STAGES];
  assign zero      = zero_s[PIPE_STAGES];
  assign ovf       = ovf_s[PIPE_STAGES];

endmodule
